adt7420_poll_scheduler: RTL and testbench

//  Sequences one ADT7420 temperature read: START, addr+W, ptr, rSTART, addr+R, MSB(ACK), LSB(NACK), STOP.

---
 rtl/adt7420_poll_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_adt7420_poll_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_poll_scheduler.sv
// Sequences one ADT7420 temperature read over a byte-level I2C master engine
// and publishes the last good 13-bit sample; launches on trigger or poll timer.
module adt7420_poll_scheduler #(
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter logic [7:0]  REG_PTR     = 8'h00,
    parameter logic [23:0] POLL_PERIOD = 24'd1000,
    parameter int unsigned MAX_RETRY   = 2,
    parameter logic [15:0] TIMEOUT     = 16'd4000
) (
    input  logic        FSM_Clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        poll_en,
    input  logic        clear_err,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic        busy,
    output logic [7:0]  temp_msb,
    output logic [7:0]  temp_lsb,
    output logic [12:0] temp_raw13,
    output logic        sample_valid,
    output logic        nack_err,
    output logic        tmo_err,
    output logic [2:0]  retry_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WADR, S_WPTR, S_RSTART,
        S_RADR, S_RMSB, S_RLSB, S_STOP, S_DONE
    } state_t;

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_ACK  = 3'd2;
    localparam logic [2:0] OP_READ_NACK = 3'd3;
    localparam logic [2:0] OP_STOP      = 3'd4;
    localparam logic [2:0] OP_RSTART    = 3'd5;
    localparam logic [2:0] MAX_RETRY_C  = 3'(MAX_RETRY);

    state_t      state_reg, state_next;
    logic        issued_reg, issued_next;
    logic        nacked_reg, nacked_next;
    logic [15:0] tmo_cnt_reg, tmo_cnt_next;
    logic [23:0] poll_cnt_reg, poll_cnt_next;
    logic        pending_reg, pending_next;
    logic [2:0]  retry_reg, retry_next;
    logic [7:0]  msb_shadow_reg, msb_shadow_next;
    logic [7:0]  lsb_shadow_reg, lsb_shadow_next;
    logic [7:0]  temp_msb_reg, temp_msb_next;
    logic [7:0]  temp_lsb_reg, temp_lsb_next;
    logic        sample_valid_reg, sample_valid_next;
    logic        nack_err_reg, nack_err_next;
    logic        tmo_err_reg, tmo_err_next;

    logic        is_cmd_state;
    logic [2:0]  op_sel;
    logic [7:0]  data_sel;
    logic        launch, tick, nack_set, tmo_set, xfer, done;

    // Command presented by each state; constant for as long as the state is held.
    always_comb begin
        is_cmd_state = 1'b1;
        op_sel       = OP_START;
        data_sel     = 8'h00;
        case (state_reg)
            S_START:  op_sel = OP_START;
            S_WADR:   begin op_sel = OP_WRITE; data_sel = {DEV_ADDR, 1'b0}; end
            S_WPTR:   begin op_sel = OP_WRITE; data_sel = REG_PTR; end
            S_RSTART: op_sel = OP_RSTART;
            S_RADR:   begin op_sel = OP_WRITE; data_sel = {DEV_ADDR, 1'b1}; end
            S_RMSB:   op_sel = OP_READ_ACK;
            S_RLSB:   op_sel = OP_READ_NACK;
            S_STOP:   op_sel = OP_STOP;
            default:  is_cmd_state = 1'b0;
        endcase
    end

    assign cmd_valid = is_cmd_state & ~issued_reg;
    assign cmd_op    = op_sel;
    assign cmd_data  = data_sel;
    assign xfer      = cmd_valid & cmd_ready;
    assign done      = is_cmd_state & issued_reg & rsp_valid;
    assign tick      = poll_en && (poll_cnt_reg == POLL_PERIOD - 24'd1);

    always_comb begin
        state_next        = state_reg;
        issued_next       = issued_reg;
        nacked_next       = nacked_reg;
        tmo_cnt_next      = tmo_cnt_reg;
        retry_next        = retry_reg;
        msb_shadow_next   = msb_shadow_reg;
        lsb_shadow_next   = lsb_shadow_reg;
        temp_msb_next     = temp_msb_reg;
        temp_lsb_next     = temp_lsb_reg;
        sample_valid_next = 1'b0;
        launch            = 1'b0;
        nack_set          = 1'b0;
        tmo_set           = 1'b0;

        case (state_reg)
            S_IDLE: begin
                tmo_cnt_next = 16'd0;
                issued_next  = 1'b0;
                if (trigger || pending_reg) begin
                    launch      = 1'b1;
                    state_next  = S_START;
                    retry_next  = 3'd0;
                    nacked_next = 1'b0;
                end
            end
            S_DONE: begin
                temp_msb_next     = msb_shadow_reg;
                temp_lsb_next     = lsb_shadow_reg;
                sample_valid_next = 1'b1;
                state_next        = S_IDLE;
            end
            default: begin
                if (done) begin
                    issued_next  = 1'b0;
                    tmo_cnt_next = 16'd0;
                    case (state_reg)
                        S_START:  state_next = S_WADR;
                        S_WADR:   begin nacked_next = rsp_nack; state_next = rsp_nack ? S_STOP : S_WPTR; end
                        S_WPTR:   begin nacked_next = rsp_nack; state_next = rsp_nack ? S_STOP : S_RSTART; end
                        S_RSTART: state_next = S_RADR;
                        S_RADR:   begin nacked_next = rsp_nack; state_next = rsp_nack ? S_STOP : S_RMSB; end
                        S_RMSB:   begin msb_shadow_next = rsp_data; state_next = S_RLSB; end
                        S_RLSB:   begin lsb_shadow_next = rsp_data; state_next = S_STOP; end
                        default: begin
                            // STOP completed: either a clean read or the tail of a NACKed attempt
                            if (!nacked_reg) begin
                                state_next = S_DONE;
                            end else if (retry_reg < MAX_RETRY_C) begin
                                retry_next  = retry_reg + 3'd1;
                                nacked_next = 1'b0;
                                state_next  = S_START;
                            end else begin
                                nack_set   = 1'b1;
                                state_next = S_IDLE;
                            end
                        end
                    endcase
                end else if (!xfer && (tmo_cnt_reg >= TIMEOUT - 16'd1)) begin
                    tmo_set     = 1'b1;
                    issued_next = 1'b0;
                    state_next  = S_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 16'd1;
                    if (xfer) issued_next = 1'b1;
                end
            end
        endcase
    end

    // One-deep request latch: ticks and triggers seen while busy coalesce into one launch.
    assign poll_cnt_next = (!poll_en || tick) ? 24'd0 : poll_cnt_reg + 24'd1;
    assign pending_next  = launch ? 1'b0 : (pending_reg | tick | trigger);
    assign nack_err_next = nack_set ? 1'b1 : (clear_err ? 1'b0 : nack_err_reg);
    assign tmo_err_next  = tmo_set  ? 1'b1 : (clear_err ? 1'b0 : tmo_err_reg);

    always_ff @(posedge FSM_Clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            issued_reg       <= 1'b0;
            nacked_reg       <= 1'b0;
            tmo_cnt_reg      <= 16'd0;
            poll_cnt_reg     <= 24'd0;
            pending_reg      <= 1'b0;
            retry_reg        <= 3'd0;
            msb_shadow_reg   <= 8'h00;
            lsb_shadow_reg   <= 8'h00;
            temp_msb_reg     <= 8'h00;
            temp_lsb_reg     <= 8'h00;
            sample_valid_reg <= 1'b0;
            nack_err_reg     <= 1'b0;
            tmo_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            issued_reg       <= issued_next;
            nacked_reg       <= nacked_next;
            tmo_cnt_reg      <= tmo_cnt_next;
            poll_cnt_reg     <= poll_cnt_next;
            pending_reg      <= pending_next;
            retry_reg        <= retry_next;
            msb_shadow_reg   <= msb_shadow_next;
            lsb_shadow_reg   <= lsb_shadow_next;
            temp_msb_reg     <= temp_msb_next;
            temp_lsb_reg     <= temp_lsb_next;
            sample_valid_reg <= sample_valid_next;
            nack_err_reg     <= nack_err_next;
            tmo_err_reg      <= tmo_err_next;
        end
    end

    assign busy         = (state_reg != S_IDLE);
    assign temp_msb     = temp_msb_reg;
    assign temp_lsb     = temp_lsb_reg;
    assign temp_raw13   = {temp_msb_reg, temp_lsb_reg[7:3]};
    assign sample_valid = sample_valid_reg;
    assign nack_err     = nack_err_reg;
    assign tmo_err      = tmo_err_reg;
    assign retry_cnt    = retry_reg;

endmodule

// File: tb/tb_adt7420_poll_scheduler.sv
// Scoreboard bench: an engine model answers commands, expected command streams and
// samples are queued by a transaction-level model, and monitors pop and compare.
module tb_adt7420_poll_scheduler;

    localparam logic [6:0]  DEV_ADDR  = 7'h48;
    localparam logic [7:0]  REG_PTR   = 8'h00;
    localparam int          POLL      = 1000;
    localparam int          MAX_RETRY = 2;
    localparam int          TIMEOUT   = 4000;

    logic        FSM_Clk = 1'b0;
    logic        reset = 1'b1, trigger = 1'b0, poll_en = 1'b0, clear_err = 1'b0;
    logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_nack = 1'b0;
    logic [7:0]  rsp_data = 8'h00;
    logic        cmd_valid, busy, sample_valid, nack_err, tmo_err;
    logic [2:0]  cmd_op, retry_cnt;
    logic [7:0]  cmd_data, temp_msb, temp_lsb;
    logic [12:0] temp_raw13;

    adt7420_poll_scheduler #(
        .DEV_ADDR(DEV_ADDR), .REG_PTR(REG_PTR), .POLL_PERIOD(24'(POLL)),
        .MAX_RETRY(MAX_RETRY), .TIMEOUT(16'(TIMEOUT))
    ) dut (
        .FSM_Clk(FSM_Clk), .reset(reset), .trigger(trigger), .poll_en(poll_en),
        .clear_err(clear_err), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_nack(rsp_nack), .busy(busy),
        .temp_msb(temp_msb), .temp_lsb(temp_lsb), .temp_raw13(temp_raw13),
        .sample_valid(sample_valid), .nack_err(nack_err), .tmo_err(tmo_err),
        .retry_cnt(retry_cnt)
    );

    always #5 FSM_Clk = ~FSM_Clk;

    int cyc = 0;
    always @(posedge FSM_Clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // Scoreboard queues and transaction-level model state
    logic [10:0] exp_cmd_q[$];
    logic [15:0] exp_smp_q[$];
    logic [7:0]  exp_msb = 8'h00, exp_lsb = 8'h00;
    int          exp_retry = 0;
    bit          exp_nack_err = 1'b0;

    // Engine configuration
    logic [7:0]  msb_val = 8'h00, lsb_val = 8'h00;
    bit          nack_wadr = 1'b0, withhold_ra = 1'b0, rand_timing = 1'b0;
    int          stall_once = 0, rsp_dly = 2;
    int          start_cnt = 0, ra_cyc = 0;
    int          start_cyc[$];
    bit          saw_rn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected engine traffic for one launch; mode 0 full read, 1 NACK on every
    // address phase, 2 abandoned after READ_ACK, 3 abandoned after READ_NACK.
    task automatic push_txn(input int mode);
        int attempts;
        attempts = (mode == 1) ? MAX_RETRY + 1 : 1;
        for (int a = 0; a < attempts; a++) begin
            exp_cmd_q.push_back({3'd0, 8'h00});
            exp_cmd_q.push_back({3'd1, DEV_ADDR, 1'b0});
            if (mode == 1) exp_cmd_q.push_back({3'd4, 8'h00});
        end
        if (mode == 1) begin
            exp_retry = MAX_RETRY;
            exp_nack_err = 1'b1;
            return;
        end
        exp_retry = 0;
        exp_cmd_q.push_back({3'd1, REG_PTR});
        exp_cmd_q.push_back({3'd5, 8'h00});
        exp_cmd_q.push_back({3'd1, DEV_ADDR, 1'b1});
        exp_cmd_q.push_back({3'd2, 8'h00});
        if (mode == 2) return;
        exp_cmd_q.push_back({3'd3, 8'h00});
        if (mode == 3) return;
        exp_cmd_q.push_back({3'd4, 8'h00});
        exp_smp_q.push_back({msb_val, lsb_val});
        exp_msb = msb_val;
        exp_lsb = lsb_val;
    endtask

    // Engine model plus command monitor
    initial begin : engine
        bit pend, seen;
        int cd, stall_left;
        logic [2:0] p_op, h_op;
        logic [7:0] p_data, h_data;
        logic [10:0] e;
        pend = 1'b0; seen = 1'b0; cd = 0; stall_left = 0;
        p_op = 3'd0; h_op = 3'd0; p_data = 8'h00; h_data = 8'h00;
        forever begin
            @(negedge FSM_Clk);
            rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00; cmd_ready = 1'b0;
            if (reset) begin
                pend = 1'b0;
                seen = 1'b0;
            end else if (pend) begin
                check("one_outstanding", 32'(cmd_valid), 32'd0);
                cd--;
                if (cd <= 0) begin
                    pend = 1'b0;
                    rsp_valid = 1'b1;
                    rsp_data = 8'($urandom);
                    if (p_op == 3'd2) rsp_data = msb_val;
                    else if (p_op == 3'd3) rsp_data = lsb_val;
                    if (p_op == 3'd2 || p_op == 3'd3) rsp_nack = rand_timing ? 1'($urandom) : 1'b0;
                    else if (p_op == 3'd1 && p_data == {DEV_ADDR, 1'b0}) rsp_nack = nack_wadr;
                end
            end else if (cmd_valid) begin
                if (!seen) begin
                    seen = 1'b1; h_op = cmd_op; h_data = cmd_data;
                    if (stall_once > 0) begin
                        stall_left = stall_once;
                        stall_once = 0;
                    end else begin
                        stall_left = rand_timing ? int'($urandom_range(0, 3)) : 0;
                    end
                end else begin
                    check("cmd_stable", 32'({cmd_op, cmd_data}), 32'({h_op, h_data}));
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    cmd_ready = 1'b1;
                    seen = 1'b0;
                    if (exp_cmd_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL cmd_extra: got op %0d data 0x%02h, expected no command", cmd_op, cmd_data);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        check("cmd", 32'({cmd_op, cmd_data}), 32'(e));
                    end
                    if (cmd_op == 3'd0) begin start_cnt++; start_cyc.push_back(cyc); end
                    if (cmd_op == 3'd2) ra_cyc = cyc;
                    if (cmd_op == 3'd3) saw_rn = 1'b1;
                    if (!(withhold_ra && cmd_op == 3'd2)) begin
                        pend = 1'b1;
                        cd = rand_timing ? int'($urandom_range(1, 4)) : rsp_dly;
                        p_op = cmd_op; p_data = cmd_data;
                    end
                end
            end
        end
    end

    // Sample monitor
    initial begin : sample_mon
        logic [15:0] e;
        forever begin
            @(negedge FSM_Clk);
            if (!reset && sample_valid) begin
                if (exp_smp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sample_extra: got msb 0x%02h lsb 0x%02h, expected no sample", temp_msb, temp_lsb);
                end else begin
                    e = exp_smp_q.pop_front();
                    check("temp_msb", 32'(temp_msb), 32'(e[15:8]));
                    check("temp_lsb", 32'(temp_lsb), 32'(e[7:0]));
                    check("temp_raw13", 32'(temp_raw13), 32'(e >> 3));
                    $display("sample msb=0x%02h lsb=0x%02h raw13=0x%04h at cycle %0d", temp_msb, temp_lsb, temp_raw13, cyc);
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 20000) begin @(negedge FSM_Clk); k++; end
        check({name, "_idle"}, 32'(busy), 32'd0);
        @(negedge FSM_Clk);
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge FSM_Clk);
        trigger = 1'b0;
    endtask

    task automatic check_state(input string name);
        check({name, "_msb"}, 32'(temp_msb), 32'(exp_msb));
        check({name, "_lsb"}, 32'(temp_lsb), 32'(exp_lsb));
        check({name, "_raw13"}, 32'(temp_raw13), 32'({exp_msb, exp_lsb} >> 3));
        check({name, "_retry"}, 32'(retry_cnt), 32'(exp_retry));
        check({name, "_nack_err"}, 32'(nack_err), 32'(exp_nack_err));
        check({name, "_cmd_q"}, 32'(exp_cmd_q.size()), 32'd0);
        check({name, "_smp_q"}, 32'(exp_smp_q.size()), 32'd0);
        $display("transaction %s done at cycle %0d, starts so far %0d", name, cyc, start_cnt);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s0, k;
        repeat (3) @(negedge FSM_Clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_temp_msb", 32'(temp_msb), 32'd0);
        check("rst_temp_lsb", 32'(temp_lsb), 32'd0);
        check("rst_raw13", 32'(temp_raw13), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_errs", 32'({nack_err, tmo_err}), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);
        reset = 1'b0;
        @(negedge FSM_Clk);

        // Known reading
        msb_val = 8'h19; lsb_val = 8'h80;
        push_txn(0); pulse_trigger(); wait_idle("t1");
        check("t1_raw13_literal", 32'(temp_raw13), 32'h330);
        check_state("t1");

        // Randomised readings and engine timing
        rand_timing = 1'b1;
        for (int i = 0; i < 6; i++) begin
            msb_val = 8'($urandom); lsb_val = 8'($urandom);
            push_txn(0); pulse_trigger(); wait_idle("rand");
            check_state("rand");
        end
        rand_timing = 1'b0;

        // Address NACK on every attempt
        nack_wadr = 1'b1; msb_val = 8'($urandom); lsb_val = 8'($urandom);
        s0 = start_cnt;
        push_txn(1); pulse_trigger(); wait_idle("t2");
        nack_wadr = 1'b0;
        check("t2_starts", 32'(start_cnt - s0), 32'(MAX_RETRY + 1));
        check_state("t2");
        clear_err = 1'b1; @(negedge FSM_Clk); clear_err = 1'b0;
        exp_nack_err = 1'b0;
        check("t2_clear", 32'(nack_err), 32'd0);

        // Ready withheld for 10 cycles on the first command
        msb_val = 8'($urandom); lsb_val = 8'($urandom);
        stall_once = 10;
        push_txn(0); pulse_trigger(); wait_idle("t4");
        check_state("t4");

        // Periodic polling
        msb_val = 8'($urandom); lsb_val = 8'($urandom);
        repeat (3) push_txn(0);
        s0 = start_cnt; start_cyc.delete();
        poll_en = 1'b1;
        repeat (3500) @(negedge FSM_Clk);
        poll_en = 1'b0;
        wait_idle("t3a");
        check("t3a_launches", 32'(start_cnt - s0), 32'd3);
        if (start_cyc.size() == 3) begin
            check("t3a_period1", 32'(start_cyc[1] - start_cyc[0]), 32'(POLL));
            check("t3a_period2", 32'(start_cyc[2] - start_cyc[1]), 32'(POLL));
        end
        check_state("t3a");

        // Trigger during a polled read adds exactly one read
        repeat (4) push_txn(0);
        s0 = start_cnt;
        poll_en = 1'b1;
        k = 0;
        while (!busy && k < 1200) begin @(negedge FSM_Clk); k++; end
        check("t3b_first_launch", 32'(busy), 32'd1);
        repeat (5) @(negedge FSM_Clk);
        pulse_trigger();
        repeat (2300) @(negedge FSM_Clk);
        poll_en = 1'b0;
        wait_idle("t3b");
        check("t3b_launches", 32'(start_cnt - s0), 32'd4);
        check_state("t3b");

        // Response withheld after READ_ACK
        withhold_ra = 1'b1;
        push_txn(2); pulse_trigger();
        k = 0;
        while (!tmo_err && k < TIMEOUT + 200) begin @(negedge FSM_Clk); k++; end
        check("t5_tmo_err", 32'(tmo_err), 32'd1);
        check("t5_tmo_delay", 32'(cyc - ra_cyc), 32'(TIMEOUT));
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cmd_valid", 32'(cmd_valid), 32'd0);
        withhold_ra = 1'b0;
        @(negedge FSM_Clk);
        check_state("t5");
        clear_err = 1'b1; @(negedge FSM_Clk); clear_err = 1'b0;
        check("t5_clear", 32'(tmo_err), 32'd0);

        // Reset during the LSB read
        rsp_dly = 6; saw_rn = 1'b0;
        push_txn(3); pulse_trigger();
        k = 0;
        while (!saw_rn && k < 200) begin @(negedge FSM_Clk); k++; end
        check("t6_reached_rlsb", 32'(saw_rn), 32'd1);
        @(negedge FSM_Clk);
        reset = 1'b1;
        @(negedge FSM_Clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cmd_valid", 32'(cmd_valid), 32'd0);
        check("t6_temp", 32'({temp_msb, temp_lsb}), 32'd0);
        check("t6_sample_valid", 32'(sample_valid), 32'd0);
        @(negedge FSM_Clk);
        reset = 1'b0; rsp_dly = 2;
        exp_msb = 8'h00; exp_lsb = 8'h00; exp_retry = 0; exp_nack_err = 1'b0;
        @(negedge FSM_Clk);
        check_state("t6");

        // Recovery after reset
        msb_val = 8'($urandom); lsb_val = 8'($urandom);
        push_txn(0); pulse_trigger(); wait_idle("t6r");
        check_state("t6r");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
